// File: rtl/mtm_alu_deserializer.sv
// Serial-line receiver for ALU requests. It decodes 11-bit frames into B, A and a command byte,
// and reports packet/length/framing events as one-cycle strobes.
module mtm_alu_deserializer #(
  parameter int unsigned DATA_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] B,
  output logic [31:0] A,
  output logic [2:0]  OP,
  output logic [3:0]  CRC,
  output logic        pkt_valid,
  output logic        err_data,
  output logic        err_frame
);

  localparam int unsigned CntW = $clog2(DATA_FRAMES + 1);
  localparam logic [CntW-1:0] FramesFull = CntW'(DATA_FRAMES);

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StPayload,
    StStop,
    StResync
  } state_e;

  state_e          r_state;
  logic            r_is_cmd;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_byte_sr;
  logic [63:0]     r_acc;
  logic [CntW-1:0] r_frame_cnt;
  logic            r_ovf;
  // Outcome decided at the stop bit, applied to the outputs one cycle later.
  logic            r_pend_ok;
  logic            r_pend_ed;
  logic            r_pend_ef;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_is_cmd    <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte_sr   <= 8'd0;
      r_acc       <= 64'd0;
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
      r_pend_ok   <= 1'b0;
      r_pend_ed   <= 1'b0;
      r_pend_ef   <= 1'b0;
      B           <= 32'd0;
      A           <= 32'd0;
      OP          <= 3'd0;
      CRC         <= 4'd0;
      pkt_valid   <= 1'b0;
      err_data    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      pkt_valid <= r_pend_ok;
      err_data  <= r_pend_ed;
      err_frame <= r_pend_ef;
      r_pend_ok <= 1'b0;
      r_pend_ed <= 1'b0;
      r_pend_ef <= 1'b0;
      // The cycle after a stop bit is IDLE or a start bit, so r_acc and r_byte_sr are stable.
      if (r_pend_ok) begin
        B   <= r_acc[63:32];
        A   <= r_acc[31:0];
        OP  <= r_byte_sr[6:4];
        CRC <= r_byte_sr[3:0];
      end

      case (r_state)
        StIdle: begin
          if (!sin) r_state <= StType;
        end
        StType: begin
          r_is_cmd  <= sin;
          r_bit_cnt <= 3'd7;
          r_state   <= StPayload;
        end
        StPayload: begin
          r_byte_sr <= {r_byte_sr[6:0], sin};
          if (r_bit_cnt == 3'd0) begin
            r_state <= StStop;
          end else begin
            r_bit_cnt <= r_bit_cnt - 3'd1;
          end
        end
        StStop: begin
          if (sin) begin
            r_state <= StIdle;
            if (!r_is_cmd) begin
              if (r_frame_cnt < FramesFull) begin
                r_acc       <= {r_acc[55:0], r_byte_sr};
                r_frame_cnt <= r_frame_cnt + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else begin
              if ((r_frame_cnt == FramesFull) && !r_ovf) begin
                r_pend_ok <= 1'b1;
              end else begin
                r_pend_ed <= 1'b1;
              end
              r_frame_cnt <= '0;
              r_ovf       <= 1'b0;
            end
          end else begin
            r_pend_ef   <= 1'b1;
            r_frame_cnt <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= 64'd0;
            r_state     <= StResync;
          end
        end
        StResync: begin
          // A stuck-low line must not be taken as a stream of start bits.
          if (sin) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Bench for mtm_alu_deserializer: table of packets plus hand-built error sequences, checked
// against a scoreboard of expected strobe events.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic [31:0] B;
  logic [31:0] A;
  logic [2:0]  OP;
  logic [3:0]  CRC;
  logic        pkt_valid;
  logic        err_data;
  logic        err_frame;

  mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .B        (B),
    .A        (A),
    .OP       (OP),
    .CRC      (CRC),
    .pkt_valid(pkt_valid),
    .err_data (err_data),
    .err_frame(err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] KOk = 3'b100;
  localparam logic [2:0] KEd = 3'b010;
  localparam logic [2:0] KEf = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  crc;
    int          due;
  } ev_t;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [7:0]  cmd;
    logic [2:0]  op;
    logic [3:0]  crc;
    bit          gaps;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[5];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] hold_b = 32'd0;
  logic [31:0] hold_a = 32'd0;
  logic [2:0]  hold_op = 3'd0;
  logic [3:0]  hold_crc = 4'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    logic [2:0] obs;
    ev_t e;
    obs = {pkt_valid, err_data, err_frame};
    if (sb.size() > 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      chk("missed_strobe", 64'(obs), 64'(e.kind));
    end
    if (obs != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'(obs), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 64'(obs), 64'(e.kind));
        chk("strobe_cycle", 64'(cyc), 64'(e.due));
        chk("out_B", 64'(B), 64'(e.b));
        chk("out_A", 64'(A), 64'(e.a));
        chk("out_OP", 64'(OP), 64'(e.op));
        chk("out_CRC", 64'(CRC), 64'(e.crc));
      end
    end
  end

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic is_cmd, input logic [7:0] byte_v, input logic stop);
    send_bit(1'b0);
    send_bit(is_cmd);
    for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
    send_bit(stop);
  endtask

  // Called right after a stop bit: the strobe lands one cycle after the sampling edge.
  task automatic push_ev(input logic [2:0] kind);
    ev_t e;
    e.kind = kind;
    e.b    = hold_b;
    e.a    = hold_a;
    e.op   = hold_op;
    e.crc  = hold_crc;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic send_packet(input vec_t v);
    logic [63:0] w;
    w = {v.b, v.a};
    for (int k = 0; k < 8; k++) begin
      send_frame(1'b0, w[63-8*k -: 8], 1'b1);
      if (v.gaps) send_idle($urandom_range(0, 5));
    end
    send_frame(1'b1, v.cmd, 1'b1);
    hold_b   = v.b;
    hold_a   = v.a;
    hold_op  = v.op;
    hold_crc = v.crc;
    push_ev(KOk);
  endtask

  initial begin
    vecs[0] = '{b: 32'h0000_0002, a: 32'h0000_0003, cmd: 8'h0B, op: 3'd0, crc: 4'hB, gaps: 0};
    vecs[1] = '{b: 32'hDEAD_BEEF, a: 32'h0123_4567, cmd: 8'h27, op: 3'd2, crc: 4'h7, gaps: 0};
    vecs[2] = '{b: 32'h1357_2468, a: 32'h9ABC_DEF0, cmd: 8'hDA, op: 3'd5, crc: 4'hA, gaps: 0};
    vecs[3] = '{b: 32'hFFFF_FFFF, a: 32'h8000_0000, cmd: 8'h4F, op: 3'd4, crc: 4'hF, gaps: 0};
    vecs[4] = '{b: 32'h0000_0002, a: 32'h0000_0003, cmd: 8'h0B, op: 3'd0, crc: 4'hB, gaps: 1};

    sin   = 1'b1;
    rst_n = 1'b0;
    send_idle(3);
    rst_n = 1'b1;
    chk("reset_outputs", {B, A}, 64'd0);
    chk("reset_op_crc_strobes", {57'd0, OP, CRC, pkt_valid, err_data, err_frame}, 64'd0);
    send_idle(2);

    for (int i = 0; i < 5; i++) begin
      case (i)
        1: begin
          // Short packet: 4 data frames then a command.
          for (int k = 0; k < 4; k++) send_frame(1'b0, 8'hAA, 1'b1);
          send_frame(1'b1, 8'h15, 1'b1);
          push_ev(KEd);
          send_idle(2);
        end
        2: begin
          // Overlong packet: 9 data frames then a command.
          for (int k = 0; k < 9; k++) send_frame(1'b0, 8'(k + 1), 1'b1);
          send_frame(1'b1, 8'h33, 1'b1);
          push_ev(KEd);
          send_idle(2);
          // Framing error on the third data frame, then a stuck-low line.
          send_frame(1'b0, 8'h11, 1'b1);
          send_frame(1'b0, 8'h22, 1'b1);
          send_frame(1'b0, 8'h33, 1'b0);
          push_ev(KEf);
          for (int k = 0; k < 20; k++) send_bit(1'b0);
          send_idle(3);
        end
        3: begin
          // Reset during frame 5's payload.
          for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h5A, 1'b1);
          send_bit(1'b0);
          send_bit(1'b0);
          send_bit(1'b1);
          send_bit(1'b0);
          rst_n = 1'b0;
          send_bit(1'b1);
          rst_n = 1'b1;
          chk("midreset_outputs", {B, A}, 64'd0);
          chk("midreset_op_crc", {57'd0, OP, CRC, pkt_valid, err_data, err_frame}, 64'd0);
          hold_b   = 32'd0;
          hold_a   = 32'd0;
          hold_op  = 3'd0;
          hold_crc = 4'd0;
          send_idle(4);
        end
        default: ;
      endcase
      send_packet(vecs[i]);
      send_idle(3);
      chk("held_B", 64'(B), 64'(vecs[i].b));
      chk("held_CRC", 64'(CRC), 64'(vecs[i].crc));
    end

    send_idle(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_deserializer.md
Name: mtm_alu_deserializer

Overview:
Receive-side counterpart of the ALU result serializer. It decodes the serial input line `sin` into one ALU request: operand B, operand A and a command byte holding OP and CRC. It sits between the chip input pin and the ALU core/CRC checker. Results are presented as registered words with a one-cycle `pkt_valid` strobe, and malformed traffic is reported on single-cycle error strobes.

Parameters:
- DATA_FRAMES, 8, number of data frames in a well-formed packet (4 for B, then 4 for A).

Ports:
- clk  in  1  posedge clock; one serial bit per cycle.
- rst_n  in  1  synchronous, active-low reset.
- sin  in  1  serial input; idles high.
- B  out  32  operand B, from the first 4 data frames.
- A  out  32  operand A, from data frames 5–8.
- OP  out  3  command byte bits [6:4].
- CRC  out  4  command byte bits [3:0].
- pkt_valid  out  1  one-cycle strobe; A/B/OP/CRC are valid.
- err_data  out  1  one-cycle strobe; a command frame arrived after a data-frame count other than DATA_FRAMES.
- err_frame  out  1  one-cycle strobe; a stop bit was sampled as 0.

Behaviour:

Reset and general rules
- Reset (rst_n=0 sampled at posedge):
  - all outputs go to 0;
  - state goes to IDLE;
  - frame counter, bit counter and shift registers clear.
- Reset asserted mid-frame or mid-packet abandons the packet with no strobes.
- Sampling: `sin` is sampled on every posedge. No oversampling and no input synchroniser (that lives at the pad ring).

Frame format (11 cycles)
- start bit = 0
- type bit: 0 = data, 1 = command
- 8 payload bits, MSB first
- stop bit = 1

Packet format
- DATA_FRAMES data frames: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24], …, A[7:0].
- Then one command frame: {1'b0, OP[2:0], CRC[3:0]}.
- Command bit 7 is ignored.

FSM states
- IDLE:
  - sin=0 → TYPE (this cycle is the start bit);
  - otherwise stay.
- TYPE: latch the type bit; bit_cnt=7; → PAYLOAD.
- PAYLOAD: shift sin into byte_sr; at bit_cnt=0 → STOP, else decrement.
- STOP:
  - sin=1 and type=data:
    - if frame_cnt < DATA_FRAMES: shift byte_sr into the 64-bit {B,A} accumulator and increment frame_cnt;
    - if frame_cnt = DATA_FRAMES: set the overflow flag and leave the accumulator unchanged;
    - → IDLE.
  - sin=1 and type=command:
    - if frame_cnt == DATA_FRAMES and no overflow: next cycle load A, B, OP, CRC and pulse pkt_valid;
    - otherwise: pulse err_data and leave outputs unchanged;
    - clear frame_cnt and overflow; → IDLE.
  - sin=0: next cycle pulse err_frame; clear frame_cnt, overflow and accumulator; → RESYNC.
- RESYNC: wait for sin=1, then → IDLE. This prevents a stuck-low line from being decoded as start bits.

Timing
- If the stop bit is sampled at cycle N, strobes and output updates are visible after the posedge at N+1.
- Strobes are high for exactly one cycle.
- A/B/OP/CRC hold their value until the next pkt_valid.
- Back-to-back frames are supported: a start bit in the cycle immediately after a stop bit is accepted. IDLE is entered straight from STOP, so there is no gap requirement.
- pkt_valid, err_data and err_frame are mutually exclusive.
- A packet's total length is 9 × 11 = 99 cycles. pkt_valid rises 1 cycle after the final stop bit.

Test Plan:
1. Reset, then a well-formed packet: B=0x00000002, A=0x00000003, cmd=0x0B (OP=000, CRC=0xB), sent back-to-back with no idle gaps.
   - Required: pkt_valid high for exactly 1 cycle, 1 cycle after the final stop bit.
   - Required: B=0x00000002, A=0x00000003, OP=0, CRC=0xB; both error strobes stay 0.
2. Short packet: 4 data frames (0xAA each) then command 0x15.
   - Required: err_data pulses once, pkt_valid stays 0, A/B/OP/CRC keep their previous values.
   - Then a full packet B=0xDEADBEEF, A=0x01234567, cmd=0x27 must be accepted normally (OP=2, CRC=7).
3. Overlong packet: 9 data frames then a command.
   - Required: a single err_data pulse and no pkt_valid.
4. Frame error: third data frame sent with stop bit 0, then sin held low for 20 cycles, then high, then a full packet.
   - Required: exactly one err_frame pulse and no decoding while sin is low.
   - Required: the following packet is decoded correctly.
5. Reset mid-packet: rst_n low for 1 cycle during frame 5's payload, then a full packet B=0xFFFFFFFF, A=0x80000000, cmd=0x4F.
   - Required: no strobes around the reset, and outputs equal 0 after it.
   - Required: the later packet yields exactly those values (OP=4, CRC=0xF).
6. Idle gaps: random 0–5 cycle gaps of sin=1 between frames of one packet.
   - Required: result identical to scenario 1.
